// File: rtl/wb_resp_pkg.sv
// Shared types and bus widths for the Wishbone RAM responder.
package wb_resp_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } wb_resp_state_e;

endpackage

// File: rtl/wb_resp_mem.sv
// Single-port byte-lane-write synchronous RAM; rdata is the word at idx one cycle later.
module wb_resp_mem
    import wb_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [WB_SEL_W-1:0]            sel,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [WB_DAT_W-1:0]            wdata,
    output logic [WB_DAT_W-1:0]            rdata
);

    logic [WB_DAT_W-1:0] ram [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WB_SEL_W; i++) begin
                if (sel[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= ram[idx];
    end

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone B4 classic RAM responder with programmable wait states and a stretch input.
// Define WB_RESP_ERR_EN to add bus__err and terminate out-of-range accesses with an error.
module wb_ram_responder
    import wb_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WB_ADR_W-1:0] bus__adr,
    input  logic                bus__cyc,
    input  logic                bus__stb,
    input  logic                bus__we,
    input  logic [WB_SEL_W-1:0] bus__sel,
    input  logic [WB_DAT_W-1:0] bus__dat_w,
    output logic [WB_DAT_W-1:0] bus__dat_r,
    output logic                bus__ack,
    input  logic                wait_req
`ifdef WB_RESP_ERR_EN
    ,
    output logic                bus__err
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WCNT_INIT = 4'(WAIT_STATES - 1);

    wb_resp_state_e       state;
    logic [3:0]           wcnt;
    logic [WB_ADR_W-1:0]  adr_q;
    logic                 we_q;
    logic [WB_SEL_W-1:0]  sel_q;
    logic [WB_DAT_W-1:0]  dat_w_q;
    logic [WB_DAT_W-1:0]  mem_rdata;
    logic [IDX_W-1:0]     mem_idx;
    logic                 complete;
    logic                 oor;
    logic                 mem_we;

    always_ff @(posedge clk) begin
        if (state == IDLE && bus__cyc && bus__stb) begin
            adr_q   <= bus__adr;
            we_q    <= bus__we;
            sel_q   <= bus__sel;
            dat_w_q <= bus__dat_w;
        end
    end

`ifdef WB_RESP_ERR_EN
    assign oor = |(adr_q >> IDX_W);
`else
    logic unused_adr_hi;
    assign unused_adr_hi = |(adr_q >> IDX_W);
    assign oor = 1'b0;
`endif

    // Address the RAM from the live bus while idle so the read word is ready by completion.
    assign mem_idx  = (state == IDLE) ? bus__adr[IDX_W-1:0] : adr_q[IDX_W-1:0];
    assign complete = (state == WAIT) && bus__cyc && (wcnt == 4'd0) && !wait_req;
    assign mem_we   = complete && we_q && !oor;

    wb_resp_mem #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .sel  (sel_q),
        .idx  (mem_idx),
        .wdata(dat_w_q),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wcnt       <= 4'd0;
            bus__ack   <= 1'b0;
            bus__dat_r <= '0;
        end else begin
            bus__ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus__cyc && bus__stb) begin
                        wcnt  <= WCNT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!bus__cyc) begin
                        state <= IDLE;
                    end else if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end else if (!wait_req) begin
                        state <= ACK;
                        if (!oor) begin
                            bus__ack <= 1'b1;
                            if (!we_q) bus__dat_r <= mem_rdata;
                        end
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_RESP_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus__err <= 1'b0;
        else     bus__err <= complete && oor;
    end
`endif

endmodule
